// File: rtl/edge_evt_pkg.sv
// Shared constants for the edge-event arbiter.
//   MODE_*  : per-channel {fall_en,rise_en} encodings
//   KIND_*  : value presented on evt_kind
//   ST_*    : output slot FSM states
package edge_evt_pkg;

    localparam logic [1:0] MODE_OFF  = 2'b00;
    localparam logic [1:0] MODE_RISE = 2'b01;
    localparam logic [1:0] MODE_FALL = 2'b10;
    localparam logic [1:0] MODE_BOTH = 2'b11;

    localparam logic KIND_RISE = 1'b1;
    localparam logic KIND_FALL = 1'b0;

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

endpackage

// File: rtl/edge_detect_ch.sv
// Per-channel level-to-pulse edge detector.
//   clk, rst  : clock, synchronous active-high reset
//   level     : synchronised level input
//   rise_en   : qualify rising edges
//   fall_en   : qualify falling edges
//   rise      : raw rising edge this cycle
//   q         : qualified edge (rise&rise_en | fall&fall_en)
module edge_detect_ch (
    input  logic clk,
    input  logic rst,
    input  logic level,
    input  logic rise_en,
    input  logic fall_en,
    output logic rise,
    output logic q
);

    logic prev_lvl;
    logic fall;

    // prev_lvl clears on reset, so a level already high at release is a rise.
    always_ff @(posedge clk) begin
        if (rst) prev_lvl <= 1'b0;
        else     prev_lvl <= level;
    end

    assign rise = level & ~prev_lvl;
    assign fall = ~level & prev_lvl;
    assign q    = (rise & rise_en) | (fall & fall_en);

endmodule

// File: rtl/edge_event_arbiter.sv
// Multi-channel edge-event controller: NCH edge detectors, one pending event
// per channel, round-robin sharing of a single valid/ready event port.
//   clk, rst   : clock, synchronous active-high reset
//   level_in   : per-channel synchronised levels
//   mode       : per channel {fall_en,rise_en} at mode[2i+1:2i]
//   evt_valid  : event presented on evt_ch/evt_kind
//   evt_ready  : consumer accept
//   evt_ch     : channel index of presented event
//   evt_kind   : 1 rising, 0 falling
//   overflow   : sticky per-channel dropped-event flags
//   ovf_clr    : clear all overflow bits (set wins)
module edge_event_arbiter
    import edge_evt_pkg::*;
#(
    parameter int NCH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NCH-1:0]                level_in,
    input  logic [2*NCH-1:0]              mode,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic [$clog2(NCH)-1:0]        evt_ch,
    output logic                          evt_kind,
    output logic [NCH-1:0]                overflow,
    input  logic                          ovf_clr
);

    localparam int IDW = $clog2(NCH);

    logic [NCH-1:0] rise, q, pending, kind, take, ovf_set;
    logic [IDW-1:0] rr_ptr, winner;
    logic [0:0]     state;
    logic           any_pend, load;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        edge_detect_ch u_det (
            .clk     (clk),
            .rst     (rst),
            .level   (level_in[i]),
            .rise_en (mode[2*i]),
            .fall_en (mode[2*i+1]),
            .rise    (rise[i]),
            .q       (q[i])
        );
    end

    // First set bit of req searching ptr, ptr+1, ... mod NCH.
    function automatic logic [IDW-1:0] rr_pick(input logic [NCH-1:0] req,
                                               input logic [IDW-1:0] ptr);
        logic [IDW-1:0] pick;
        logic [IDW-1:0] ix;
        logic           found;
        pick  = ptr;
        found = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            ix = IDW'((int'(ptr) + k) % NCH);
            if (!found && req[ix]) begin
                pick  = ix;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign any_pend  = |pending;
    assign evt_valid = (state == ST_FULL);
    // Load the slot when it is empty or being drained this cycle.
    assign load      = any_pend && ((state == ST_EMPTY) || evt_ready);
    assign winner    = rr_pick(pending, rr_ptr);

    always_comb begin
        take    = '0;
        ovf_set = '0;
        for (int i = 0; i < NCH; i++) begin
            take[i]    = load && (winner == IDW'(i));
            // A channel being loaded frees its pending slot for the new edge.
            ovf_set[i] = q[i] && pending[i] && !take[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_EMPTY;
            pending  <= '0;
            kind     <= '0;
            rr_ptr   <= '0;
            evt_ch   <= '0;
            evt_kind <= 1'b0;
            overflow <= '0;
        end else begin
            if ((state == ST_EMPTY) || evt_ready)
                state <= any_pend ? ST_FULL : ST_EMPTY;

            if (load) begin
                evt_ch   <= winner;
                evt_kind <= kind[winner];
                rr_ptr   <= (winner == IDW'(NCH-1)) ? '0 : winner + 1'b1;
            end

            for (int i = 0; i < NCH; i++) begin
                if (q[i] && (!pending[i] || take[i])) begin
                    pending[i] <= 1'b1;
                    kind[i]    <= rise[i];
                end else if (take[i]) begin
                    pending[i] <= 1'b0;
                end
            end

            overflow <= (ovf_clr ? '0 : overflow) | ovf_set;
        end
    end

endmodule

// File: tb/tb_edge_event_arbiter.sv
module tb_edge_event_arbiter;
    import edge_evt_pkg::*;

    typedef struct packed {
        logic [1:0] ch;
        logic       kind;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] level_in;
    logic [7:0] mode;
    logic       evt_valid;
    logic       evt_ready;
    logic [1:0] evt_ch;
    logic       evt_kind;
    logic [3:0] overflow;
    logic       ovf_clr;

    exp_t sbq[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    edge_event_arbiter #(.NCH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .level_in  (level_in),
        .mode      (mode),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_ch    (evt_ch),
        .evt_kind  (evt_kind),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic push(input int ch, input logic kind);
        exp_t e;
        e.ch   = 2'(ch);
        e.kind = kind;
        sbq.push_back(e);
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while (sbq.size() != 0 && n < 50) begin
            step();
            n++;
        end
        chk({nm, "_drain"}, sbq.size(), 0);
        repeat (4) step();
    endtask

    // Monitor: every accepted event must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && evt_valid && evt_ready) begin
            n_cmp++;
            if (sbq.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_evt: got ch=%0d kind=%0d, expected none",
                         evt_ch, evt_kind);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                if (evt_ch !== e.ch || evt_kind !== e.kind) begin
                    n_fail++;
                    $display("FAIL evt: got ch=%0d kind=%0d, expected ch=%0d kind=%0d",
                             evt_ch, evt_kind, e.ch, e.kind);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; level_in = 4'b0000; mode = {4{MODE_BOTH}};
        evt_ready = 1'b1; ovf_clr = 1'b0;
        repeat (3) step();

        // 1. Reset state
        rst = 1'b0;
        @(negedge clk);
        chk("t1_valid", evt_valid, 0);
        chk("t1_ovf", overflow, 0);
        chk("t1_ch", evt_ch, 0);
        chk("t1_kind", evt_kind, 0);
        step();
        @(negedge clk);
        chk("t1_valid2", evt_valid, 0);

        // 2. ch1 rise-only: two-edge latency, single cycle, fall ignored
        step();
        mode = {MODE_OFF, MODE_OFF, MODE_RISE, MODE_OFF};
        level_in[1] = 1'b1; push(1, KIND_RISE);
        @(negedge clk); chk("t2_lat0", evt_valid, 0);
        step();
        @(negedge clk); chk("t2_lat1", evt_valid, 0);
        step();
        @(negedge clk);
        chk("t2_valid", evt_valid, 1);
        chk("t2_ch", evt_ch, 1);
        chk("t2_kind", evt_kind, 1);
        @(negedge clk); chk("t2_one", evt_valid, 0);
        step();
        level_in[1] = 1'b0;
        drain("t2");

        // 3. Fresh reset (rr_ptr=0), all channels both edges, burst order 0..3
        rst = 1'b1; level_in = 4'b0000; mode = {4{MODE_BOTH}};
        repeat (2) step();
        rst = 1'b0;
        step();
        for (int ph = 0; ph < 2; ph++) begin
            level_in = (ph == 0) ? 4'b1111 : 4'b0000;
            for (int k = 0; k < 4; k++) push(k, (ph == 0) ? KIND_RISE : KIND_FALL);
            step();
            @(negedge clk); chk("t3_gap", evt_valid, 0);
            for (int k = 0; k < 4; k++) begin
                step();
                @(negedge clk);
                chk("t3_b2b_valid", evt_valid, 1);
                chk("t3_b2b_ch", evt_ch, k);
            end
            step();
            @(negedge clk); chk("t3_end", evt_valid, 0);
            step();
        end
        drain("t3");

        // 4. Backpressure on ch2: hold, overflow, release, clear
        evt_ready = 1'b0;
        level_in[2] = 1'b1; push(2, KIND_RISE);
        repeat (3) step();
        level_in[2] = 1'b0; push(2, KIND_FALL);
        repeat (2) step();
        level_in[2] = 1'b1;            // dropped: ch2 already pending
        repeat (2) step();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t4_hold_valid", evt_valid, 1);
            chk("t4_hold_ch", evt_ch, 2);
            chk("t4_hold_kind", evt_kind, 1);
            step();
        end
        @(negedge clk); chk("t4_ovf_set", overflow, 4'b0100);
        step();
        evt_ready = 1'b1;
        drain("t4");
        chk("t4_ovf_sticky", overflow, 4'b0100);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        @(negedge clk); chk("t4_ovf_clr", overflow, 0);

        // 5. ch0 edges again while being loaded: both delivered, no overflow
        step();
        level_in[0] = 1'b1; push(0, KIND_RISE);
        step();
        level_in[0] = 1'b0; push(0, KIND_FALL);
        step();
        drain("t5");
        chk("t5_ovf", overflow, 0);

        // 6. Reset mid-handshake with pending=1010
        evt_ready = 1'b0;
        level_in[0] = 1'b1;
        repeat (2) step();
        level_in[1] = 1'b1; level_in[3] = 1'b1;
        step();
        @(negedge clk); chk("t6_full", evt_valid, 1);
        step();
        rst = 1'b1; mode = {4{MODE_OFF}};
        sbq.delete();
        step();
        @(negedge clk);
        chk("t6_rst_valid", evt_valid, 0);
        chk("t6_rst_ch", evt_ch, 0);
        chk("t6_rst_ovf", overflow, 0);
        step();
        rst = 1'b0; evt_ready = 1'b1;
        repeat (6) step();
        @(negedge clk); chk("t6_no_stale", evt_valid, 0);
        step();
        mode = {4{MODE_BOTH}};
        level_in[0] = 1'b0; push(0, KIND_FALL);
        drain("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
